// File: rtl/pim_cmd_sequencer.sv
// pim_cmd_sequencer: upstream command master for the PIM CFU.
// A job loads job_len weight words from a small FIFO into consecutive PIM rows
// (one write command per word), then issues MAC_STEPS+MAC_FLUSH process
// commands. The data of the last process response is returned as the result.
// Only one CFU command is ever outstanding.
// Optional build macro PIM_SEQ_PERF_EN adds a 32-bit saturating busy-cycle
// counter on port perf_cycles.
module pim_cmd_sequencer #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int MAC_STEPS  = 32,
  parameter int MAC_FLUSH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  // job request
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [7:0]        job_base_addr,
  input  logic [7:0]        job_len,
  // weight word stream
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DWIDTH-1:0] wdata,
  // CFU command port
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [AWIDTH-1:0] m_cmd_function_id,
  output logic [DWIDTH-1:0] m_cmd_inputs_0,
  output logic [DWIDTH-1:0] m_cmd_inputs_1,
  // CFU response port
  input  logic              m_rsp_valid,
  output logic              m_rsp_ready,
  input  logic [DWIDTH-1:0] m_rsp_outputs_0,
  // job result
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic              busy
`ifdef PIM_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int TOTAL  = MAC_STEPS + MAC_FLUSH;
  localparam int STEP_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STEP_W-1:0] STEP_LAST     = STEP_W'(TOTAL);
  localparam logic [1:0]        OP_WRITE      = 2'b01;
  localparam logic [1:0]        OP_PROCESS    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_RSP,
    S_MAC_CMD,
    S_MAC_RSP,
    S_DONE
  } state_t;

  // Row address sits in the top 8 bits, op in the bottom 2, zeros between.
  function automatic logic [AWIDTH-1:0] make_fid(input logic [7:0] row,
                                                 input logic [1:0] op);
    logic [AWIDTH-1:0] f;
    f                = '0;
    f[AWIDTH-1 -: 8] = row;
    f[1:0]           = op;
    return f;
  endfunction

  // ------------------------------------------------------------------
  // Weight-word FIFO. The head is read combinationally so it can be
  // presented as write-command data without an extra bubble; it only
  // changes on a pop, so the command stays stable under backpressure.
  // ------------------------------------------------------------------
  logic [DWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DWIDTH-1:0] fifo_head;

  assign fifo_full   = (cnt_q == FIFO_FULL_CNT);
  assign fifo_empty  = (cnt_q == '0);
  assign fifo_push   = wdata_valid && !fifo_full;
  assign wdata_ready = !fifo_full;
  assign fifo_head   = fifo_mem[rd_ptr_q];

  // Storage array: no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (fifo_push && !fifo_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer/occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [7:0]        base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DWIDTH-1:0] res_q, res_d;

  logic              cmd_hs;
  logic              wr_rsp_done;
  logic              mac_rsp_done;
  logic [7:0]        idx_inc;
  logic [STEP_W-1:0] step_inc;

  assign cmd_hs   = m_cmd_valid && m_cmd_ready;
  assign idx_inc  = idx_q + 8'd1;
  assign step_inc = step_q + STEP_W'(1);

  // Next-state and output decode; a response arriving in the same cycle as
  // the command handshake is consumed immediately, skipping the *_RSP wait.
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    len_d             = len_q;
    idx_d             = idx_q;
    step_d            = step_q;
    res_d             = res_q;
    job_ready         = 1'b0;
    m_cmd_valid       = 1'b0;
    m_cmd_function_id = '0;
    m_cmd_inputs_0    = '0;
    m_rsp_ready       = 1'b0;
    res_valid         = 1'b0;
    fifo_pop          = 1'b0;
    wr_rsp_done       = 1'b0;
    mac_rsp_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          base_d  = job_base_addr;
          len_d   = job_len;
          idx_d   = 8'd0;
          step_d  = '0;
          state_d = (job_len != 8'd0) ? S_WR_CMD : S_MAC_CMD;
        end
      end

      S_WR_CMD: begin
        m_rsp_ready       = 1'b1;
        m_cmd_valid       = !fifo_empty;
        m_cmd_function_id = make_fid(base_q + idx_q, OP_WRITE);
        m_cmd_inputs_0    = fifo_head;
        if (cmd_hs) begin
          fifo_pop = 1'b1;
          if (m_rsp_valid) begin
            wr_rsp_done = 1'b1;
          end else begin
            state_d = S_WR_RSP;
          end
        end
      end

      S_WR_RSP: begin
        m_rsp_ready = 1'b1;
        if (m_rsp_valid) begin
          wr_rsp_done = 1'b1;
        end
      end

      S_MAC_CMD: begin
        m_rsp_ready       = 1'b1;
        m_cmd_valid       = 1'b1;
        m_cmd_function_id = make_fid(8'd0, OP_PROCESS);
        if (cmd_hs) begin
          if (m_rsp_valid) begin
            mac_rsp_done = 1'b1;
          end else begin
            state_d = S_MAC_RSP;
          end
        end
      end

      S_MAC_RSP: begin
        m_rsp_ready = 1'b1;
        if (m_rsp_valid) begin
          mac_rsp_done = 1'b1;
        end
      end

      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Write response data is ignored; only the word index advances.
    if (wr_rsp_done) begin
      idx_d   = idx_inc;
      state_d = (idx_inc == len_q) ? S_MAC_CMD : S_WR_CMD;
    end

    // Every process response overwrites the result; the last one sticks.
    if (mac_rsp_done) begin
      step_d  = step_inc;
      res_d   = m_rsp_outputs_0;
      state_d = (step_inc == STEP_LAST) ? S_DONE : S_MAC_CMD;
    end
  end

  assign m_cmd_inputs_1 = '0;
  assign res_data       = res_q;
  assign busy           = (state_q != S_IDLE);

  // FSM state and job-context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      res_q   <= res_d;
    end
  end

`ifdef PIM_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Active-cycle counter: cleared on job accept, counts WR/MAC states only,
  // saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && job_valid) begin
      perf_q <= '0;
    end else if (state_q != S_IDLE && state_q != S_DONE && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pim_cmd_sequencer.sv
// Bench for pim_cmd_sequencer: a queue-based job model plus a randomised CFU
// responder. Every cycle the DUT outputs are compared against the model;
// directed jobs add literal expectations on the command log and result.
module tb_pim_cmd_sequencer;

  localparam int DW        = 32;
  localparam int AW        = 10;
  localparam int DEPTH     = 8;
  localparam int TOTAL_MAC = 35;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [7:0]    job_base_addr = '0;
  logic [7:0]    job_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          m_cmd_valid;
  logic          m_cmd_ready;
  logic [AW-1:0] m_cmd_function_id;
  logic [DW-1:0] m_cmd_inputs_0;
  logic [DW-1:0] m_cmd_inputs_1;
  logic          m_rsp_valid;
  logic          m_rsp_ready;
  logic [DW-1:0] m_rsp_outputs_0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          busy;
`ifdef PIM_SEQ_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  pim_cmd_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_base_addr     (job_base_addr),
    .job_len           (job_len),
    .wdata_valid       (wdata_valid),
    .wdata_ready       (wdata_ready),
    .wdata             (wdata),
    .m_cmd_valid       (m_cmd_valid),
    .m_cmd_ready       (m_cmd_ready),
    .m_cmd_function_id (m_cmd_function_id),
    .m_cmd_inputs_0    (m_cmd_inputs_0),
    .m_cmd_inputs_1    (m_cmd_inputs_1),
    .m_rsp_valid       (m_rsp_valid),
    .m_rsp_ready       (m_rsp_ready),
    .m_rsp_outputs_0   (m_rsp_outputs_0),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .busy              (busy)
`ifdef PIM_SEQ_PERF_EN
    ,
    .perf_cycles       (perf_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs (written by the main sequence at negedge).
  int   rdy_pct    = 100;
  int   max_lat    = 0;
  int   wd_pct     = 100;
  int   res_pct    = 100;
  bit   force_1234 = 1'b0;
  logic [DW-1:0] supply [$];

  // CFU responder state.
  logic          cmd_ready_r = 1'b0;
  int            lat_cur = 0;
  bit            pending = 1'b0;
  int            wait_cnt = 0;
  bit            pend_isw = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] fresh_data = '0;

  assign m_cmd_ready     = cmd_ready_r && !pending;
  assign m_rsp_valid     = pending ? (wait_cnt == 0) : (m_cmd_valid && m_cmd_ready && lat_cur == 0);
  assign m_rsp_outputs_0 = pending ? pend_data : fresh_data;

  // Behavioural model of the job in flight.
  logic [DW-1:0] mq [$];
  bit            active = 1'b0;
  bit            done = 1'b0;
  logic [7:0]    mbase = '0;
  logic [7:0]    mlen = '0;
  int            widx = 0;
  int            macn = 0;
  logic [DW-1:0] res_exp = '0;
  logic [31:0]   perf_exp = '0;
  bit            synced = 1'b0;
  bit            have_sample = 1'b0;
  logic [AW-1:0] log_fid [$];
  logic [DW-1:0] log_d0 [$];

  // Values sampled just before each rising edge.
  bit            f_rst, f_job, f_push, f_cmd, f_isw, f_res;
  int            f_lat;
  logic [7:0]    f_base, f_len;
  logic [DW-1:0] f_wd, f_fresh, f_d0;
  logic [AW-1:0] f_fid;

  task automatic rsp_effect(input bit isw, input logic [DW-1:0] data);
    if (isw) begin
      widx++;
    end else begin
      macn++;
      res_exp = data;
      if (macn == TOTAL_MAC) done = 1'b1;
    end
  endtask

  task automatic apply_edge();
    if (f_rst) begin
      mq.delete();
      active = 1'b0; done = 1'b0; widx = 0; macn = 0;
      res_exp = '0; perf_exp = '0; pending = 1'b0; wait_cnt = 0;
      synced = 1'b1;
    end else begin
      if (active && !done && perf_exp != 32'hFFFF_FFFF) perf_exp++;
      if (f_cmd) begin
        log_fid.push_back(f_fid);
        log_d0.push_back(f_d0);
        if (f_isw) void'(mq.pop_front());
        if (f_lat == 0) begin
          rsp_effect(f_isw, f_fresh);
        end else begin
          pending = 1'b1; wait_cnt = f_lat - 1; pend_data = f_fresh; pend_isw = f_isw;
        end
      end else if (pending) begin
        if (wait_cnt == 0) begin
          pending = 1'b0;
          rsp_effect(pend_isw, pend_data);
        end else begin
          wait_cnt--;
        end
      end
      if (f_push) begin
        mq.push_back(f_wd);
        void'(supply.pop_front());
      end
      if (f_res) begin
        $display("job base=%02h len=%0d cmds=%0d result=%08h", mbase, mlen, log_fid.size(), res_exp);
        done = 1'b0; active = 1'b0;
      end
      if (f_job) begin
        active = 1'b1; mbase = f_base; mlen = f_len; widx = 0; macn = 0; perf_exp = '0;
      end
    end
  endtask

  // Single driver/monitor process: update model for the last edge, drive
  // the next cycle's inputs, then compare settled outputs against the model.
  always begin
    bit            exp_valid;
    logic [7:0]    erow;
    @(negedge clk);
    if (have_sample) apply_edge();
    cmd_ready_r = ($urandom_range(99) < rdy_pct);
    lat_cur     = int'($urandom_range(max_lat));
    if (force_1234 && active && !done && widx >= int'(mlen) && macn == TOTAL_MAC - 1)
      fresh_data = 32'h0000_1234;
    else
      fresh_data = $urandom;
    wdata_valid = (supply.size() > 0) && ($urandom_range(99) < wd_pct);
    wdata       = (supply.size() > 0) ? supply[0] : '0;
    res_ready   = ($urandom_range(99) < res_pct);
    #1;
    if (synced) begin
      exp_valid = active && !done && !pending && ((widx < int'(mlen)) ? (mq.size() > 0) : 1'b1);
      chk("busy", busy, active);
      chk("job_ready", job_ready, !active);
      chk("wdata_ready", wdata_ready, mq.size() < DEPTH);
      chk("res_valid", res_valid, done);
      if (done) chk("res_data", res_data, res_exp);
      chk("rsp_ready", m_rsp_ready, active && !done);
      chk("cmd_valid", m_cmd_valid, exp_valid);
      chk("cmd_in1", m_cmd_inputs_1, '0);
      if (exp_valid) begin
        if (widx < int'(mlen)) begin
          erow = mbase + 8'(widx);
          chk("wr_fid", m_cmd_function_id, {erow, 2'b01});
          chk("wr_data", m_cmd_inputs_0, mq[0]);
        end else begin
          chk("mac_fid", m_cmd_function_id, 10'h002);
          chk("mac_data", m_cmd_inputs_0, '0);
        end
      end
`ifdef PIM_SEQ_PERF_EN
      chk("perf", perf_cycles, perf_exp);
`endif
    end
    f_rst   = reset;
    f_job   = job_valid && !active;
    f_push  = wdata_valid && (mq.size() < DEPTH);
    f_wd    = wdata;
    f_cmd   = m_cmd_valid && m_cmd_ready;
    f_isw   = (widx < int'(mlen));
    f_fid   = m_cmd_function_id;
    f_d0    = m_cmd_inputs_0;
    f_lat   = lat_cur;
    f_fresh = fresh_data;
    f_res   = res_ready && done;
    f_base  = job_base_addr;
    f_len   = job_len;
    have_sample = 1'b1;
  end

  task automatic run_job(input logic [7:0] b, input logic [7:0] l, input int hold);
    @(negedge clk);
    log_fid.delete();
    log_d0.delete();
    job_base_addr = b;
    job_len       = l;
    job_valid     = 1'b1;
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      job_base_addr = 8'($urandom);
      job_len       = 8'($urandom);
      @(negedge clk);
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    #3;
    while (active && n < 5000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (active) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    #3;
    while (!done && n < 5000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=no_result required=result", name);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Load: three words into rows 0x10..0x12, then 35 process commands.
    supply.push_back(32'hA); supply.push_back(32'hB); supply.push_back(32'hC);
    run_job(8'h10, 8'd3, 0);
    wait_idle("load");
    chk("load_count", log_fid.size(), 38);
    chk("load_fid0", log_fid[0], 10'h041);
    chk("load_fid1", log_fid[1], 10'h045);
    chk("load_fid2", log_fid[2], 10'h049);
    chk("load_d0", log_d0[0], 32'hA);
    chk("load_d1", log_d0[1], 32'hB);
    chk("load_d2", log_d0[2], 32'hC);
    chk("load_mac_first", log_fid[3], 10'h002);
    chk("load_mac_last", log_fid[37], 10'h002);

    // Stalls: FIFO runs dry mid-load, CFU applies backpressure and latency.
    @(negedge clk);
    rdy_pct = 50; max_lat = 3;
    supply.push_back(32'h1111); supply.push_back(32'h2222);
    run_job(8'h40, 8'd5, 2);
    for (int i = 0; i < 2000 && !(widx == 2 && !pending); i++) begin
      @(negedge clk);
      #3;
    end
    repeat (6) @(negedge clk);
    #3;
    chk("stall_novalid", m_cmd_valid, 1'b0);
    @(negedge clk);
    supply.push_back(32'h3333); supply.push_back(32'h4444); supply.push_back(32'h5555);
    wait_idle("stall");
    chk("stall_count", log_fid.size(), 40);
    chk("stall_d4", log_d0[4], 32'h5555);

    // Result hold: 35th process response is 0x1234, res_ready held low.
    @(negedge clk);
    rdy_pct = 100; max_lat = 1; force_1234 = 1'b1; res_pct = 0;
    supply.push_back(32'h77);
    run_job(8'h20, 8'd1, 0);
    wait_done("result");
    chk("model_res", res_exp, 32'h1234);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      chk("res_hold_valid", res_valid, 1'b1);
      chk("res_hold_data", res_data, 32'h1234);
    end
    @(negedge clk);
    res_pct = 100; force_1234 = 1'b0;
    wait_idle("result");
    chk("res_busy_drop", busy, 1'b0);

    // Row wrap and skip-load jobs.
    max_lat = 0;
    supply.push_back(32'hF0); supply.push_back(32'hF1);
    run_job(8'hFF, 8'd2, 0);
    wait_idle("wrap");
    chk("wrap_fid0", log_fid[0], 10'h3FD);
    chk("wrap_fid1", log_fid[1], 10'h001);
    for (int i = 0; i < 4; i++) supply.push_back(32'($urandom));
    run_job(8'hFE, 8'd4, 0);
    wait_idle("wrap4");
    chk("wrap4_fid2", log_fid[2], 10'h001);
    chk("wrap4_fid3", log_fid[3], 10'h005);
    run_job(8'h33, 8'd0, 0);
    wait_idle("skip");
    chk("skip_count", log_fid.size(), 35);
    chk("skip_fid0", log_fid[0], 10'h002);

`ifdef PIM_SEQ_PERF_EN
    supply.push_back(32'h99);
    run_job(8'h05, 8'd1, 0);
    wait_done("perf");
    chk("perf_lit", perf_cycles, 32'd36);
    wait_idle("perf");
`endif

    // Reset mid-load: abandon the job, flush the FIFO.
    @(negedge clk);
    rdy_pct = 30; max_lat = 2;
    for (int i = 0; i < 8; i++) supply.push_back(32'($urandom));
    run_job(8'h80, 8'd10, 0);
    repeat (6) @(negedge clk);
    supply.delete();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_cmd_valid", m_cmd_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_wdata_ready", wdata_ready, 1'b1);
    chk("rst_res_data", res_data, '0);
    @(negedge clk);
    reset = 1'b0;
    rdy_pct = 100; max_lat = 0;
    run_job(8'h01, 8'd1, 0);
    repeat (10) @(negedge clk);
    #3;
    chk("rst_fifo_empty", log_fid.size(), 0);
    @(negedge clk);
    supply.push_back(32'hCAFE_0001);
    wait_idle("post_reset");
    chk("post_rst_count", log_fid.size(), 36);
    chk("post_rst_d0", log_d0[0], 32'hCAFE_0001);

    // Randomised jobs with surplus words carried across jobs.
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      rdy_pct = int'($urandom_range(100, 30));
      max_lat = int'($urandom_range(3));
      wd_pct  = int'($urandom_range(100, 30));
      res_pct = int'($urandom_range(100, 30));
      len     = int'($urandom_range(12));
      for (int k = 0; k < len + int'($urandom_range(2)); k++) supply.push_back(32'($urandom));
      run_job(8'($urandom), 8'(len), int'($urandom_range(6)));
      wait_idle("random");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
